// File: rtl/fft_addr_sched.sv
// Address sequencer for an in-place radix-2 DIT FFT: issues butterfly read/twiddle
// addresses stage by stage and replays them as write-back addresses PIPE cycles later.
module fft_addr_sched #(
   parameter int N_LOG2 = 8,
   parameter int PIPE   = 3
) (
   input  logic                             iCLK,
   input  logic                             iRESET,
   input  logic                             iSTART,
   input  logic                             iABORT,
   output logic                             oRD_EN,
   output logic [N_LOG2-1:0]                oRD_ADDR_A,
   output logic [N_LOG2-1:0]                oRD_ADDR_B,
   output logic [N_LOG2-2:0]                oTW_ADDR,
   output logic                             oWR_EN,
   output logic [N_LOG2-1:0]                oWR_ADDR_A,
   output logic [N_LOG2-1:0]                oWR_ADDR_B,
   output logic [$clog2(N_LOG2+1)-1:0]      oSTAGE,
   output logic                             oBUSY,
   output logic                             oDONE
);

   localparam int KW = N_LOG2 - 1;
   localparam int SW = $clog2(N_LOG2 + 1);
   localparam int DW = (PIPE > 1) ? $clog2(PIPE) : 1;

   localparam logic [KW-1:0]     K_LAST = '1;
   localparam logic [KW-1:0]     K_ONE  = KW'(1);
   localparam logic [SW-1:0]     S_LAST = SW'(N_LOG2 - 1);
   localparam logic [SW-1:0]     S_ONE  = SW'(1);
   localparam logic [DW-1:0]     D_LAST = DW'(PIPE - 1);
   localparam logic [DW-1:0]     D_ONE  = DW'(1);
   localparam logic [N_LOG2-1:0] N_ONE  = N_LOG2'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [SW-1:0]     s_reg, s_next;
   logic [KW-1:0]     k_reg, k_next;
   logic [DW-1:0]     d_reg, d_next;

   logic              rd_en_reg;
   logic [N_LOG2-1:0] rd_a_reg;
   logic [N_LOG2-1:0] rd_b_reg;
   logic [KW-1:0]     tw_reg;
   logic [SW-1:0]     stage_reg;
   logic              busy_reg;
   logic              done_reg;

   // Next-state logic; abort overrides everything, including a start in IDLE.
   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      k_next     = k_reg;
      d_next     = d_reg;
      if (iABORT) begin
         state_next = S_IDLE;
         s_next     = '0;
         k_next     = '0;
         d_next     = '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (iSTART) begin
                  state_next = S_RUN;
                  s_next     = '0;
                  k_next     = '0;
                  d_next     = '0;
               end
            end
            S_RUN: begin
               if (k_reg != K_LAST) begin
                  k_next = k_reg + K_ONE;
               end else begin
                  state_next = S_DRAIN;
                  d_next     = '0;
               end
            end
            S_DRAIN: begin
               if (d_reg != D_LAST) begin
                  d_next = d_reg + D_ONE;
               end else if (s_reg != S_LAST) begin
                  state_next = S_RUN;
                  s_next     = s_reg + S_ONE;
                  k_next     = '0;
               end else begin
                  state_next = S_DONE;
               end
            end
            S_DONE: begin
               state_next = S_IDLE;
               s_next     = '0;
               k_next     = '0;
               d_next     = '0;
            end
            default: begin
               state_next = S_IDLE;
               s_next     = '0;
               k_next     = '0;
               d_next     = '0;
            end
         endcase
      end
   end

   // Butterfly address math on the next counter values so outputs can be registered
   // and still appear in the first RUN cycle.
   logic [N_LOG2-1:0] k_ext;
   logic [N_LOG2-1:0] half;
   logic [N_LOG2-1:0] pos;
   logic [N_LOG2-1:0] grp;
   logic [N_LOG2-1:0] a_calc;
   logic [N_LOG2-1:0] b_calc;
   logic [N_LOG2-1:0] tw_shift;
   logic [KW-1:0]     tw_calc;

   assign k_ext    = {1'b0, k_next};
   assign half     = N_ONE << s_next;
   assign pos      = k_ext & (half - N_ONE);
   assign grp      = k_ext >> s_next;
   assign a_calc   = (grp << (s_next + S_ONE)) | pos;
   assign b_calc   = a_calc | half;
   assign tw_shift = pos << (S_LAST - s_next);
   assign tw_calc  = tw_shift[KW-1:0];

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         state_reg <= S_IDLE;
         s_reg     <= '0;
         k_reg     <= '0;
         d_reg     <= '0;
         rd_en_reg <= 1'b0;
         rd_a_reg  <= '0;
         rd_b_reg  <= '0;
         tw_reg    <= '0;
         stage_reg <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         k_reg     <= k_next;
         d_reg     <= d_next;
         rd_en_reg <= (state_next == S_RUN);
         if (state_next == S_RUN) begin
            rd_a_reg <= a_calc;
            rd_b_reg <= b_calc;
            tw_reg   <= tw_calc;
         end
         stage_reg <= s_next;
         busy_reg  <= (state_next == S_RUN) || (state_next == S_DRAIN);
         done_reg  <= (state_next == S_DONE);
      end
   end

   // Write-back delay line; the read registers form the first delay so the
   // last tap lines up exactly PIPE cycles after the read.
   generate
      for (genvar gi = 0; gi < PIPE; gi++) begin : pipe_stg
         logic              v_reg;
         logic [N_LOG2-1:0] a_reg;
         logic [N_LOG2-1:0] b_reg;
         logic              v_in;
         logic [N_LOG2-1:0] a_in;
         logic [N_LOG2-1:0] b_in;

         if (gi == 0) begin : g_head
            assign v_in = rd_en_reg;
            assign a_in = rd_a_reg;
            assign b_in = rd_b_reg;
         end else begin : g_tail
            assign v_in = pipe_stg[gi-1].v_reg;
            assign a_in = pipe_stg[gi-1].a_reg;
            assign b_in = pipe_stg[gi-1].b_reg;
         end

         always_ff @(posedge iCLK or posedge iRESET) begin
            if (iRESET) begin
               v_reg <= 1'b0;
               a_reg <= '0;
               b_reg <= '0;
            end else begin
               v_reg <= v_in & ~iABORT;
               a_reg <= a_in;
               b_reg <= b_in;
            end
         end
      end
   endgenerate

   assign oRD_EN     = rd_en_reg;
   assign oRD_ADDR_A = rd_a_reg;
   assign oRD_ADDR_B = rd_b_reg;
   assign oTW_ADDR   = tw_reg;
   assign oWR_EN     = pipe_stg[PIPE-1].v_reg;
   assign oWR_ADDR_A = pipe_stg[PIPE-1].a_reg;
   assign oWR_ADDR_B = pipe_stg[PIPE-1].b_reg;
   assign oSTAGE     = stage_reg;
   assign oBUSY      = busy_reg;
   assign oDONE      = done_reg;

endmodule

// File: tb/tb_fft_addr_sched.sv
// Scoreboard bench for fft_addr_sched at N_LOG2=4, PIPE=3: expected reads come from a
// group/position model, expected writes are queued as reads are seen.
module tb_fft_addr_sched;

   localparam int N_LOG2 = 4;
   localparam int PIPE   = 3;
   localparam int N      = 16;
   localparam int HALF_N = 8;

   logic       iCLK = 1'b0;
   logic       iRESET;
   logic       iSTART;
   logic       iABORT;
   logic       oRD_EN;
   logic [3:0] oRD_ADDR_A;
   logic [3:0] oRD_ADDR_B;
   logic [2:0] oTW_ADDR;
   logic       oWR_EN;
   logic [3:0] oWR_ADDR_A;
   logic [3:0] oWR_ADDR_B;
   logic [2:0] oSTAGE;
   logic       oBUSY;
   logic       oDONE;

   fft_addr_sched #(.N_LOG2(N_LOG2), .PIPE(PIPE)) dut (
      .iCLK       (iCLK),
      .iRESET     (iRESET),
      .iSTART     (iSTART),
      .iABORT     (iABORT),
      .oRD_EN     (oRD_EN),
      .oRD_ADDR_A (oRD_ADDR_A),
      .oRD_ADDR_B (oRD_ADDR_B),
      .oTW_ADDR   (oTW_ADDR),
      .oWR_EN     (oWR_EN),
      .oWR_ADDR_A (oWR_ADDR_A),
      .oWR_ADDR_B (oWR_ADDR_B),
      .oSTAGE     (oSTAGE),
      .oBUSY      (oBUSY),
      .oDONE      (oDONE)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      int a;
      int b;
      int tw;
      int st;
      int cyc;
   } txn_t;

   txn_t rd_q[$];
   txn_t wr_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic tick;
      @(posedge iCLK);
      #1;
   endtask

   task automatic do_reset;
      iRESET = 1'b1;
      iSTART = 1'b0;
      iABORT = 1'b0;
      tick();
      @(negedge iCLK);
      iRESET = 1'b0;
   endtask

   // Expected reads enumerated group by group, position by position.
   task automatic push_model;
      txn_t t;
      for (int s = 0; s < N_LOG2; s++) begin
         int half;
         int span;
         half = 1 << s;
         span = 2 * half;
         for (int g = 0; g < N / span; g++) begin
            for (int p = 0; p < half; p++) begin
               t.a   = g * span + p;
               t.b   = t.a + half;
               t.tw  = p * (HALF_N / half);
               t.st  = s;
               t.cyc = 0;
               rd_q.push_back(t);
            end
         end
      end
   endtask

   task automatic test_reset;
      iRESET = 1'b1;
      iSTART = 1'b0;
      iABORT = 1'b0;
      repeat (3) begin
         iSTART = ~iSTART;
         tick();
      end
      checks++;
      if ({oRD_EN, oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR, oWR_EN, oWR_ADDR_A, oWR_ADDR_B,
           oSTAGE, oBUSY, oDONE} !== 26'd0) begin
         errors++;
         $display("FAIL reset_outputs got rd=%b a=%0d b=%0d tw=%0d wr=%b busy=%b done=%b expected all 0",
                  oRD_EN, oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR, oWR_EN, oBUSY, oDONE);
      end
      @(negedge iCLK);
      iRESET = 1'b0;
      iSTART = 1'b1;
      tick();
      iSTART = 1'b0;
      checks++;
      if ({oRD_EN, oBUSY, oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR, oSTAGE} !== {1'b1, 1'b1, 4'd0, 4'd1, 3'd0, 3'd0}) begin
         errors++;
         $display("FAIL first_read got rd=%b busy=%b a=%0d b=%0d tw=%0d st=%0d expected 1 1 0 1 0 0",
                  oRD_EN, oBUSY, oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR, oSTAGE);
      end
      tick();
      checks++;
      if ({oRD_ADDR_A, oRD_ADDR_B} !== {4'd2, 4'd3}) begin
         errors++;
         $display("FAIL second_read got a=%0d b=%0d expected 2 3", oRD_ADDR_A, oRD_ADDR_B);
      end
      $display("test_reset done");
   endtask

   task automatic test_full_run;
      txn_t t;
      txn_t w;
      int   reads = 0;
      int   writes = 0;
      int   ridx = 0;
      int   first_read[N_LOG2];
      int   last_write[N_LOG2];
      for (int i = 0; i < N_LOG2; i++) begin
         first_read[i] = -1;
         last_write[i] = -1;
      end
      do_reset();
      rd_q.delete();
      wr_q.delete();
      push_model();
      iSTART = 1'b1;
      tick();
      iSTART = 1'b0;
      for (int cyc = 1; cyc <= 45; cyc++) begin
         checks++;
         if (oBUSY !== (cyc <= 44)) begin
            errors++;
            $display("FAIL busy cyc=%0d got %b expected %b", cyc, oBUSY, (cyc <= 44));
         end
         checks++;
         if (oDONE !== (cyc == 45)) begin
            errors++;
            $display("FAIL done cyc=%0d got %b expected %b", cyc, oDONE, (cyc == 45));
         end
         if (oRD_EN === 1'b1) begin
            reads++;
            checks++;
            if (rd_q.size() == 0) begin
               errors++;
               $display("FAIL extra_read cyc=%0d got a=%0d expected no read", cyc, oRD_ADDR_A);
            end else begin
               t = rd_q.pop_front();
               $display("read  cyc=%0d st=%0d a=%0d b=%0d tw=%0d", cyc, oSTAGE, oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR);
               if ({oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR, oSTAGE} !== {4'(t.a), 4'(t.b), 3'(t.tw), 3'(t.st)}) begin
                  errors++;
                  $display("FAIL read_addr cyc=%0d got a=%0d b=%0d tw=%0d st=%0d expected %0d %0d %0d %0d",
                           cyc, oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR, oSTAGE, t.a, t.b, t.tw, t.st);
               end
               if (first_read[t.st] < 0) first_read[t.st] = cyc;
               t.cyc = cyc + PIPE;
               wr_q.push_back(t);
            end
            if (ridx == 21) begin
               checks++;
               if ({oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR} !== {4'd9, 4'd13, 3'd2}) begin
                  errors++;
                  $display("FAIL s2k5 got a=%0d b=%0d tw=%0d expected 9 13 2", oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR);
               end
            end
            if (ridx == 27) begin
               checks++;
               if ({oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR} !== {4'd3, 4'd11, 3'd3}) begin
                  errors++;
                  $display("FAIL s3k3 got a=%0d b=%0d tw=%0d expected 3 11 3", oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR);
               end
            end
            ridx++;
         end
         if (oWR_EN === 1'b1) begin
            writes++;
            checks++;
            if (wr_q.size() == 0) begin
               errors++;
               $display("FAIL extra_write cyc=%0d got a=%0d expected no write", cyc, oWR_ADDR_A);
            end else begin
               w = wr_q.pop_front();
               $display("write cyc=%0d a=%0d b=%0d", cyc, oWR_ADDR_A, oWR_ADDR_B);
               if ({oWR_ADDR_A, oWR_ADDR_B} !== {4'(w.a), 4'(w.b)} || cyc != w.cyc) begin
                  errors++;
                  $display("FAIL write_addr cyc=%0d got a=%0d b=%0d expected a=%0d b=%0d at cyc %0d",
                           cyc, oWR_ADDR_A, oWR_ADDR_B, w.a, w.b, w.cyc);
               end
               last_write[w.st] = cyc;
            end
         end
         iSTART = (cyc == 20 || cyc == 45);
         tick();
      end
      // cycle 46: start seen during DONE must not have launched a run
      checks++;
      if ({oRD_EN, oDONE} !== 2'b00) begin
         errors++;
         $display("FAIL after_done got rd=%b done=%b expected 0 0", oRD_EN, oDONE);
      end
      tick();
      iSTART = 1'b0;
      checks++;
      if ({oRD_EN, oRD_ADDR_A, oSTAGE} !== {1'b1, 4'd0, 3'd0}) begin
         errors++;
         $display("FAIL restart got rd=%b a=%0d st=%0d expected 1 0 0", oRD_EN, oRD_ADDR_A, oSTAGE);
      end
      checks++;
      if (reads != 32 || writes != 32 || rd_q.size() != 0 || wr_q.size() != 0) begin
         errors++;
         $display("FAIL counts got reads=%0d writes=%0d rdq=%0d wrq=%0d expected 32 32 0 0",
                  reads, writes, rd_q.size(), wr_q.size());
      end
      checks++;
      if (last_write[N_LOG2-1] != 44) begin
         errors++;
         $display("FAIL last_write got cyc=%0d expected 44", last_write[N_LOG2-1]);
      end
      for (int s = 1; s < N_LOG2; s++) begin
         checks++;
         if (first_read[s] <= last_write[s-1]) begin
            errors++;
            $display("FAIL stage_order s=%0d got first_read=%0d expected after %0d", s, first_read[s], last_write[s-1]);
         end
      end
      $display("test_full_run done");
   endtask

   task automatic test_abort;
      do_reset();
      iSTART = 1'b1;
      tick();
      iSTART = 1'b0;
      repeat (13) tick();
      checks++;
      if ({oRD_EN, oSTAGE, oRD_ADDR_A, oRD_ADDR_B} !== {1'b1, 3'd1, 4'd4, 4'd6}) begin
         errors++;
         $display("FAIL s1k2 got rd=%b st=%0d a=%0d b=%0d expected 1 1 4 6", oRD_EN, oSTAGE, oRD_ADDR_A, oRD_ADDR_B);
      end
      iABORT = 1'b1;
      tick();
      iABORT = 1'b0;
      checks++;
      if ({oRD_EN, oWR_EN, oBUSY} !== 3'b000) begin
         errors++;
         $display("FAIL abort_next got rd=%b wr=%b busy=%b expected 0 0 0", oRD_EN, oWR_EN, oBUSY);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if ({oRD_EN, oWR_EN, oDONE, oBUSY} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_idle i=%0d got rd=%b wr=%b done=%b busy=%b expected 0 0 0 0",
                     i, oRD_EN, oWR_EN, oDONE, oBUSY);
         end
      end
      iSTART = 1'b1;
      tick();
      iSTART = 1'b0;
      checks++;
      if ({oRD_EN, oRD_ADDR_A, oRD_ADDR_B, oSTAGE} !== {1'b1, 4'd0, 4'd1, 3'd0}) begin
         errors++;
         $display("FAIL abort_restart got rd=%b a=%0d b=%0d st=%0d expected 1 0 1 0",
                  oRD_EN, oRD_ADDR_A, oRD_ADDR_B, oSTAGE);
      end
      repeat (PIPE) tick();
      checks++;
      if ({oWR_EN, oWR_ADDR_A, oWR_ADDR_B} !== {1'b1, 4'd0, 4'd1}) begin
         errors++;
         $display("FAIL abort_first_write got wr=%b a=%0d b=%0d expected 1 0 1", oWR_EN, oWR_ADDR_A, oWR_ADDR_B);
      end
      $display("test_abort done");
   endtask

   task automatic test_async_reset;
      do_reset();
      iSTART = 1'b1;
      tick();
      iSTART = 1'b0;
      repeat (8) tick();
      checks++;
      if ({oBUSY, oRD_EN, oWR_EN} !== 3'b101) begin
         errors++;
         $display("FAIL drain_state got busy=%b rd=%b wr=%b expected 1 0 1", oBUSY, oRD_EN, oWR_EN);
      end
      @(negedge iCLK);
      iRESET = 1'b1;
      #1;
      checks++;
      if ({oRD_EN, oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR, oWR_EN, oWR_ADDR_A, oWR_ADDR_B,
           oSTAGE, oBUSY, oDONE} !== 26'd0) begin
         errors++;
         $display("FAIL async_reset got rd=%b a=%0d b=%0d wr=%b wa=%0d st=%0d busy=%b expected all 0",
                  oRD_EN, oRD_ADDR_A, oRD_ADDR_B, oWR_EN, oWR_ADDR_A, oSTAGE, oBUSY);
      end
      tick();
      @(negedge iCLK);
      iRESET = 1'b0;
      $display("test_async_reset done");
   endtask

   initial begin
      iRESET = 1'b1;
      iSTART = 1'b0;
      iABORT = 1'b0;
      test_reset();
      test_full_run();
      test_abort();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
